// File: rtl/button_bank.sv
// button_bank -- bank of debounced push-button channels on the system clock.
//
// Each channel passes through a two-flop synchroniser and is then debounced
// on a shared sample tick from a prescaler. A channel's clean level flips only
// after STABLE_SAMPLES consecutive ticks that disagree with it. Registered
// press/release pulses mark each flip. An optional auto-repeat pulse fires
// while the key is held.
//
// Optional feature: define BUTTON_BANK_REPEAT_EN to build the repeat counters.
// When it is undefined, repeat_o is tied to 0.
//
// Ports:
//   clk         system clock, all state on the rising edge
//   rst         synchronous active-high reset
//   btn_i       raw asynchronous button levels, 1 = pressed
//   btn_o       debounced level
//   press_o     one-cycle pulse on debounced 0->1
//   release_o   one-cycle pulse on debounced 1->0
//   repeat_o    one-cycle auto-repeat pulse while held
//   any_press_o OR of press_o, same cycle
module button_bank #(
    parameter int CHANNELS       = 5,
    parameter int SAMPLE_DIV     = 100000,
    parameter int STABLE_SAMPLES = 4,
    parameter int REPEAT_DELAY   = 50,
    parameter int REPEAT_RATE    = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] btn_i,
    output logic [CHANNELS-1:0] btn_o,
    output logic [CHANNELS-1:0] press_o,
    output logic [CHANNELS-1:0] release_o,
    output logic [CHANNELS-1:0] repeat_o,
    output logic                any_press_o
);

    localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int CNT_W = $clog2(STABLE_SAMPLES + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_SAMPLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CHANNELS-1:0] sync_p0;
    logic [CHANNELS-1:0] sync_p1;
    logic [DIV_W-1:0]    div_cnt;
    logic                tick;

    logic [CNT_W-1:0]    cnt     [CHANNELS];
    logic [CNT_W-1:0]    cnt_nxt [CHANNELS];
    logic [CHANNELS-1:0] level_nxt;
    logic [CHANNELS-1:0] rise_nxt;
    logic [CHANNELS-1:0] fall_nxt;

    // Stage p0/p1: metastability synchroniser
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= btn_i;
            sync_p1 <= sync_p0;
        end
    end

    // Shared sample prescaler; with SAMPLE_DIV=1 it sits at 0 and ticks every cycle
    assign tick = (div_cnt == DIV_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_ONE;
        end
    end

    // Debounce decision: one agreeing sample clears a pending flip
    always_comb begin
        cnt_nxt   = cnt;
        level_nxt = btn_o;
        for (int i = 0; i < CHANNELS; i++) begin
            if (tick) begin
                if (sync_p1[i] == btn_o[i]) begin
                    cnt_nxt[i] = '0;
                end else if (cnt[i] == CNT_LAST) begin
                    level_nxt[i] = ~btn_o[i];
                    cnt_nxt[i]   = '0;
                end else begin
                    cnt_nxt[i] = cnt[i] + CNT_ONE;
                end
            end
        end
        rise_nxt = level_nxt & ~btn_o;
        fall_nxt = ~level_nxt & btn_o;
    end

    // Stage p2: registered level and edge pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_o       <= '0;
            press_o     <= '0;
            release_o   <= '0;
            any_press_o <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            btn_o       <= level_nxt;
            press_o     <= rise_nxt;
            release_o   <= fall_nxt;
            any_press_o <= |rise_nxt;
            cnt         <= cnt_nxt;
        end
    end

`ifdef BUTTON_BANK_REPEAT_EN
    localparam int RCNT_W = $clog2(REPEAT_DELAY + 1);
    localparam logic [RCNT_W-1:0] RCNT_FIRE   = RCNT_W'(REPEAT_DELAY);
    localparam logic [RCNT_W-1:0] RCNT_ONE    = RCNT_W'(1);
    localparam logic [RCNT_W-1:0] RCNT_RELOAD =
        RCNT_W'((REPEAT_DELAY > REPEAT_RATE) ? (REPEAT_DELAY - REPEAT_RATE) : 0);

    logic [RCNT_W-1:0]   rcnt     [CHANNELS];
    logic [RCNT_W-1:0]   rcnt_nxt [CHANNELS];
    logic [CHANNELS-1:0] rep_nxt;

    // The counter never holds REPEAT_DELAY itself. The tick that would reach it
    // fires and reloads instead, so pulses land exactly at DELAY, DELAY+RATE, ...
    // Any flip (press or release) or a released key clears it, so a repeat
    // never shares a cycle with press_o.
    always_comb begin
        rcnt_nxt = rcnt;
        rep_nxt  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (tick) begin
                if (!btn_o[i] || (level_nxt[i] != btn_o[i])) begin
                    rcnt_nxt[i] = '0;
                end else if ((rcnt[i] + RCNT_ONE) == RCNT_FIRE) begin
                    rep_nxt[i]  = 1'b1;
                    rcnt_nxt[i] = RCNT_RELOAD;
                end else begin
                    rcnt_nxt[i] = rcnt[i] + RCNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            repeat_o <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                rcnt[i] <= '0;
            end
        end else begin
            repeat_o <= rep_nxt;
            rcnt     <= rcnt_nxt;
        end
    end
`else
    assign repeat_o = '0;
`endif

endmodule

// File: tb/tb_button_bank.sv
// tb_button_bank -- directed self-checking bench for button_bank.
// Main instance: SAMPLE_DIV=4, STABLE_SAMPLES=3, REPEAT_DELAY=5, REPEAT_RATE=2.
// Second instance: SAMPLE_DIV=1, STABLE_SAMPLES=1, single channel.
module tb_button_bank;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] btn = '0;
    logic [4:0] btn_q;
    logic [4:0] press;
    logic [4:0] rel;
    logic [4:0] rep;
    logic       any_press;

    logic [0:0] btn_f = '0;
    logic [0:0] lvl_f;
    logic [0:0] press_f;
    logic [0:0] rel_f;
    logic [0:0] rep_f;
    logic       any_f;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    button_bank #(
        .CHANNELS(5), .SAMPLE_DIV(4), .STABLE_SAMPLES(3),
        .REPEAT_DELAY(5), .REPEAT_RATE(2)
    ) dut (
        .clk(clk), .rst(rst), .btn_i(btn), .btn_o(btn_q), .press_o(press),
        .release_o(rel), .repeat_o(rep), .any_press_o(any_press)
    );

    button_bank #(
        .CHANNELS(1), .SAMPLE_DIV(1), .STABLE_SAMPLES(1),
        .REPEAT_DELAY(5), .REPEAT_RATE(2)
    ) dut_fast (
        .clk(clk), .rst(rst), .btn_i(btn_f), .btn_o(lvl_f), .press_o(press_f),
        .release_o(rel_f), .repeat_o(rep_f), .any_press_o(any_f)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Leaves the caller #1 after the last edge that sampled rst high.
    task automatic reset_dut();
        @(posedge clk); #1;
        rst   = 1'b1;
        btn   = '0;
        btn_f = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Cycles until press_o[ch] is seen (-1 on timeout); counts release_o[ch] meanwhile.
    task automatic wait_press(input int ch, input int limit, output int lat, output int rel_seen);
        lat      = -1;
        rel_seen = 0;
        for (int n = 1; n <= limit; n++) begin
            @(posedge clk); #1;
            if (rel[ch]) rel_seen++;
            if (press[ch]) begin
                lat = n;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, rel_seen, cnt_a, cnt_b, first_k, second_k;
        logic [4:0]  cap;
        logic [23:0] pat;
        logic        e_lvl, e_prev;

        // Reset state
        reset_dut();
        check("rst_outputs", {btn_q, press, rel, rep, any_press}, 32'd0);
        check("rst_fast_outputs", {lvl_f, press_f, rel_f, rep_f, any_f}, 32'd0);

        // Clean press on ch0 right after reset: 2 sync + 3 ticks (ticks at 4, 8, 12)
        btn[0] = 1'b1;
        wait_press(0, 20, lat, rel_seen);
        check("s1_latency", lat, 12);
        check("s1_level", btn_q, 5'b00001);
        check("s1_press_vec", press, 5'b00001);
        check("s1_any", any_press, 1'b1);
        cnt_a = 0;
        @(posedge clk); #1;
        check("s1_press_width", press, 5'b00000);
        for (int n = 0; n < 20; n++) begin
            if (rel != 5'b0) cnt_a++;
            @(posedge clk); #1;
        end
        check("s1_no_release", cnt_a + rel_seen, 0);

        // Bounce on ch1, period 6 cycles: never 3 consecutive equal samples
        reset_dut();
        cnt_a = 0;
        cnt_b = 0;
        for (int c = 0; c < 40; c++) begin
            btn[1] = ((c / 3) % 2) == 0;
            @(posedge clk); #1;
            if (press[1]) cnt_a++;
            if (rel[1]) cnt_b++;
        end
        check("s2_bounce_press", cnt_a, 0);
        btn[1] = 1'b1;
        cnt_a = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (press[1]) cnt_a++;
            if (rel[1]) cnt_b++;
        end
        check("s2_steady_press", cnt_a, 1);
        check("s2_no_release", cnt_b, 0);
        check("s2_level", btn_q, 5'b00010);

        // Hold ch2 for 40 ticks: repeats at ticks 5, 7, ... 39 after the press
        reset_dut();
        btn[2] = 1'b1;
        wait_press(2, 20, lat, rel_seen);
        check("s3_latency", lat, 12);
        check("s3_no_coincide", rep[2], 1'b0);
        cnt_a    = 0;
        first_k  = -1;
        second_k = -1;
        for (int k = 1; k <= 160; k++) begin
            @(posedge clk); #1;
            if (rep[2]) begin
                cnt_a++;
                if (first_k < 0) first_k = k;
                else if (second_k < 0) second_k = k;
            end
        end
`ifdef BUTTON_BANK_REPEAT_EN
        check("s3_repeat_count", cnt_a, 18);
        check("s3_first_repeat", first_k, 20);
        check("s3_second_repeat", second_k, 28);
`else
        check("s3_repeat_off", cnt_a, 0);
`endif
        btn[2] = 1'b0;
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (rel[2]) begin
                lat = n;
                break;
            end
        end
        check("s3_release_seen", (lat > 0), 1'b1);
        cnt_a = 0;
        cnt_b = 0;
        for (int n = 0; n < 100; n++) begin
            @(posedge clk); #1;
            if (rep[2]) cnt_a++;
            if (rel[2]) cnt_b++;
        end
        check("s3_no_repeat_after", cnt_a, 0);
        check("s3_single_release", cnt_b, 0);

        // ch3 and ch4 on the same cycle
        reset_dut();
        btn[4:3] = 2'b11;
        cnt_a = 0;
        cap   = '0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (any_press) begin
                cnt_a++;
                cap = press;
            end
        end
        check("s4_press_vec", cap, 5'b11000);
        check("s4_any_width", cnt_a, 1);

        // Reset while ch0 is held
        reset_dut();
        btn[0] = 1'b1;
        wait_press(0, 20, lat, rel_seen);
        check("s5_first_press", lat, 12);
        repeat (30) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("s5_rst_cycle1", {btn_q, press, rel, rep, any_press}, 32'd0);
        @(posedge clk); #1;
        check("s5_rst_cycle2", {btn_q, press, rel, rep, any_press}, 32'd0);
        rst = 1'b0;
        wait_press(0, 20, lat, rel_seen);
        check("s5_repress_latency", lat, 12);
        check("s5_no_release", rel_seen, 0);

        // Fast instance: level follows input 3 cycles later, edges on each change
        reset_dut();
        pat = 24'h0234D6;
        for (int j = 0; j < 24; j++) begin
            btn_f = pat[j];
            @(negedge clk);
            e_lvl  = (j >= 3) ? pat[j-3] : 1'b0;
            e_prev = (j >= 4) ? pat[j-4] : 1'b0;
            check("s6_level", lvl_f, e_lvl);
            check("s6_press", press_f, e_lvl & ~e_prev);
            check("s6_release", rel_f, ~e_lvl & e_prev);
            check("s6_any", any_f, e_lvl & ~e_prev);
            @(posedge clk); #1;
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
